quad_mux: RTL and testbench

//   4:1 word multiplexer for datapath source selection: one of four equal-width inputs
//     (A,B,C,D) is routed to X, chosen by a 2-bit select.

---
 rtl/quad_mux.sv | 69 ++++++
 tb/tb_quad_mux.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_mux.sv
// 4:1 word multiplexer. X is combinational. X_Q and SEL_CHG are registered copies for downstream logic.
// Optional build macro QUAD_MUX_PARITY_EN adds PAR_Q, the registered even parity of X.
module quad_mux #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       SEL,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] X_Q,
`ifdef QUAD_MUX_PARITY_EN
    output logic             SEL_CHG,
    output logic             PAR_Q
`else
    output logic             SEL_CHG
`endif
);

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] r_x_q;
    logic [1:0]       r_sel_q;
    logic             r_sel_chg;

    // An unknown select yields an all-X word rather than quietly passing A through.
    always_comb begin
        w_x = 'x;
        case (SEL)
            2'b00: w_x = A;
            2'b01: w_x = B;
            2'b10: w_x = C;
            2'b11: w_x = D;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_q     <= '0;
            r_sel_q   <= 2'b00;
            r_sel_chg <= 1'b0;
        end else begin
            r_x_q     <= w_x;
            r_sel_q   <= SEL;
            r_sel_chg <= (SEL != r_sel_q);
        end
    end

    assign X       = w_x;
    assign X_Q     = r_x_q;
    assign SEL_CHG = r_sel_chg;

`ifdef QUAD_MUX_PARITY_EN
    logic r_par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_q <= 1'b0;
        end else begin
            r_par_q <= ^w_x;
        end
    end

    assign PAR_Q = r_par_q;
`endif

endmodule

// File: tb/tb_quad_mux.sv
// Self-checking bench for quad_mux. A scoreboard queue holds the expected registered outputs of a 2-bit and an 8-bit instance.
// The queue is filled when stimulus is driven and drained after each clock edge.
`timescale 1ns/1ps
module tb_quad_mux;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst;
    logic [1:0] a2, b2, c2, d2, sel2, x2, xq2;
    logic       chg2;
    logic [7:0] a8, b8, c8, d8, x8, xq8;
    logic [1:0] sel8;
    logic       chg8;
    logic       par2;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [1:0] xq2;
        logic       chg2;
        logic       par2;
        logic [7:0] xq8;
        logic       chg8;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [12:0] obs;
    logic [1:0] m_prev2;
    logic [1:0] m_prev8;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    quad_mux #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .A(a2), .B(b2), .C(c2), .D(d2), .SEL(sel2),
        .X(x2), .X_Q(xq2),
`ifdef QUAD_MUX_PARITY_EN
        .SEL_CHG(chg2), .PAR_Q(par2)
`else
        .SEL_CHG(chg2)
`endif
    );

`ifndef QUAD_MUX_PARITY_EN
    assign par2 = 1'b0;
`endif

    quad_mux #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .C(c8), .D(d8), .SEL(sel8),
        .X(x8), .X_Q(xq8),
`ifdef QUAD_MUX_PARITY_EN
        .SEL_CHG(chg8), .PAR_Q()
`else
        .SEL_CHG(chg8)
`endif
    );

    assign obs = {xq2, chg2, par2, xq8, chg8};

    function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c,
                                        input logic [7:0] d);
        logic [7:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v[s];
    endfunction

    // Record what the next clock edge must produce for the inputs now applied.
    task automatic push_expect();
        exp_t n;
        logic [7:0] w;
        w      = pick(sel2, {6'd0, a2}, {6'd0, b2}, {6'd0, c2}, {6'd0, d2});
        n.xq2  = w[1:0];
        n.chg2 = (sel2 != m_prev2);
`ifdef QUAD_MUX_PARITY_EN
        n.par2 = ^w[1:0];
`else
        n.par2 = 1'b0;
`endif
        n.xq8  = pick(sel8, a8, b8, c8, d8);
        n.chg8 = (sel8 != m_prev8);
        m_prev2 = sel2;
        m_prev8 = sel8;
        sb.push_back(n);
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (obs !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_regs: got %h expected 0000", obs);
        end
    endtask

    task automatic test_comb_no_clock();
        logic [1:0] sels [5];
        logic [1:0] xs [5];
        sels[0] = 2'b10; sels[1] = 2'b00; sels[2] = 2'b11; sels[3] = 2'b10; sels[4] = 2'b01;
        xs[0]   = 2'b01; xs[1]   = 2'b11; xs[2]   = 2'b00; xs[3]   = 2'b01; xs[4]   = 2'b10;
        for (int i = 0; i < 5; i++) begin
            sel2 = sels[i];
            #10;
            tests_run++;
            if (x2 !== xs[i]) begin
                tests_failed++;
                $display("FAIL comb_x[%0d]: got %b expected %b", i, x2, xs[i]);
            end
        end
    endtask

    task automatic test_sel_change();
        logic [1:0] seq [3];
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            sel2 = seq[i];
            sel8 = seq[i];
            push_expect();
            @(posedge clk); #1;
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL sel_change[%0d]: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        sel2 = 2'b11;
        sel8 = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (obs !== 13'd0 || x2 !== 2'b00) begin
            tests_failed++;
            $display("FAIL async_reset: got regs=%h x=%b expected regs=0000 x=00", obs, x2);
        end
        @(negedge clk);
        rst = 1'b0;
        m_prev2 = 2'b00;
        m_prev8 = 2'b00;
        for (int i = 0; i < 2; i++) begin
            push_expect();
            @(posedge clk); #1;
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL post_reset[%0d]: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_hold();
        sel2 = 2'b10;
        sel8 = 2'b10;
        for (int i = 0; i < 6; i++) begin
            push_expect();
            @(posedge clk); #1;
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL hold[%0d]: got %h expected %h", i, obs, e);
            end
        end
        tests_run++;
        if (xq2 !== 2'b01 || chg2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_const: got xq=%b chg=%b expected xq=01 chg=0", xq2, chg2);
        end
    endtask

`ifdef QUAD_MUX_PARITY_EN
    task automatic test_parity();
        sel2 = 2'b00;
        push_expect();
        @(posedge clk); #1;
        e = sb.pop_front();
        tests_run++;
        if (par2 !== 1'b0 || obs !== e) begin
            tests_failed++;
            $display("FAIL parity_a: got par=%b obs=%h expected par=0 obs=%h", par2, obs, e);
        end
        sel2 = 2'b01;
        push_expect();
        @(posedge clk); #1;
        e = sb.pop_front();
        tests_run++;
        if (par2 !== 1'b1 || obs !== e) begin
            tests_failed++;
            $display("FAIL parity_b: got par=%b obs=%h expected par=1 obs=%h", par2, obs, e);
        end
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            a2 = 2'($urandom); b2 = 2'($urandom); c2 = 2'($urandom); d2 = 2'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
            sel2 = 2'($urandom);
            sel8 = 2'($urandom);
            push_expect();
            @(posedge clk); #1;
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, e);
            end
        end
        a2 = 2'b11; b2 = 2'b10; c2 = 2'b01; d2 = 2'b00;
    endtask

    task automatic test_wide();
        logic [7:0] xs [4];
        xs[0] = 8'hA5; xs[1] = 8'h3C; xs[2] = 8'hFF; xs[3] = 8'h00;
        a8 = 8'hA5; b8 = 8'h3C; c8 = 8'hFF; d8 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            sel8 = 2'(i);
            #1;
            tests_run++;
            if (x8 !== xs[i]) begin
                tests_failed++;
                $display("FAIL wide_x[%0d]: got %h expected %h", i, x8, xs[i]);
            end
            push_expect();
            @(posedge clk); #1;
            e = sb.pop_front();
            tests_run++;
            if (xq8 !== xs[i] || obs !== e) begin
                tests_failed++;
                $display("FAIL wide_xq[%0d]: got xq=%h obs=%h expected xq=%h obs=%h",
                         i, xq8, obs, xs[i], e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        a2 = 2'b11; b2 = 2'b10; c2 = 2'b01; d2 = 2'b00;
        a8 = 8'hA5; b8 = 8'h3C; c8 = 8'hFF; d8 = 8'h00;
        sel2 = 2'b00;
        sel8 = 2'b00;
        m_prev2 = 2'b00;
        m_prev8 = 2'b00;

        test_reset();
        test_comb_no_clock();

        sel2 = 2'b00;
        sel8 = 2'b00;
        #3;
        rst = 1'b0;
        #2;
        clk_run = 1'b1;

        test_sel_change();
        test_async_reset();
        test_hold();
`ifdef QUAD_MUX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_wide();

        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
